// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, writer FSM encoding and pixel-address helper
// for the VGA sprite pipeline.
package vga_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int FB_ADDR_W = 17;
    localparam int COLOR_W   = 3;
    localparam int FB_WORDS  = 76800;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } fb_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [COLOR_W-1:0]   color;
    } fb_pixel_t;

    // y*320 + x built from two shifts so no multiplier is needed.
    function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [8:0] x, input logic [7:0] y);
        logic [FB_ADDR_W-1:0] y_ext;
        y_ext = {9'b0, y};
        return (y_ext << 8) + (y_ext << 6) + {8'b0, x};
    endfunction

endpackage

// File: rtl/fb_pixel_writer_pixel_fifo.sv
// Small synchronous FIFO holding range-checked pixels; exposes the head and
// the entry behind it so a granted write can be followed back-to-back.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_data_next,
    output logic             full,
    output logic             empty,
    output logic             single
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign rd_ptr_next  = rd_ptr + AW'(1);
    assign rd_data      = mem[rd_ptr];
    assign rd_data_next = mem[rd_ptr_next];
    assign full         = (count == (AW+1)'(DEPTH));
    assign empty        = (count == '0);
    assign single       = (count == (AW+1)'(1));
    assign do_push      = push && !full;
    assign do_pop       = pop && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_next;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Sink of the sprite pixel stream: range-checks and queues pixels, then writes
// them (or a full-screen clear) through the grant-arbitrated framebuffer port.
module fb_pixel_writer #(
    parameter int DEPTH    = 4,
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        plot,
    input  logic [8:0]  xCoord,
    input  logic [7:0]  yCoord,
    input  logic [2:0]  color,
    output logic        in_ready,
    input  logic        clear_req,
    input  logic [2:0]  clear_color,
    output logic        clear_done,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [2:0]  fb_data,
    input  logic        fb_grant,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  oor_count
);

    import vga_pkg::*;

    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_WORDS - 1);

    fb_state_t state, state_next;

    logic                 fifo_full, fifo_empty, fifo_single, fifo_pop;
    logic [19:0]          fifo_rd, fifo_rd_next;
    fb_pixel_t            head, head_next, new_pixel;
    logic                 in_range, accept, push, clear_accept;
    logic                 clear_pending, pending_next;
    logic [COLOR_W-1:0]   clear_col_q, clear_col_next;
    logic                 we_next, done_next;
    logic [FB_ADDR_W-1:0] addr_next;
    logic [COLOR_W-1:0]   data_next;

    assign in_range  = (int'(xCoord) < SCREEN_W) && (int'(yCoord) < SCREEN_H);
    assign in_ready  = !reset && !fifo_full && !clear_pending && (state != CLEAR);
    assign accept    = plot && in_ready;
    assign push      = accept && in_range;
    assign new_pixel = '{addr: pixel_addr(xCoord, yCoord), color: color};
    assign head      = fifo_rd;
    assign head_next = fifo_rd_next;
    assign busy      = !fifo_empty || clear_pending || (state != IDLE);
    // A clear already pending or running swallows any further requests.
    assign clear_accept = clear_req && !clear_pending && (state != CLEAR);

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (20)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .wr_data      (new_pixel),
        .pop          (fifo_pop),
        .rd_data      (fifo_rd),
        .rd_data_next (fifo_rd_next),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .single       (fifo_single)
    );

    always_comb begin
        state_next     = state;
        we_next        = fb_we;
        addr_next      = fb_addr;
        data_next      = fb_data;
        done_next      = 1'b0;
        fifo_pop       = 1'b0;
        pending_next   = clear_pending;
        clear_col_next = clear_col_q;

        if (clear_accept) begin
            pending_next   = 1'b1;
            clear_col_next = clear_color;
        end

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = DRAIN;
                    we_next    = 1'b1;
                    addr_next  = head.addr;
                    data_next  = head.color;
                end else if ((clear_pending || clear_accept) && !push) begin
                    state_next = CLEAR;
                    we_next    = 1'b1;
                    addr_next  = '0;
                    data_next  = clear_accept ? clear_color : clear_col_q;
                end
            end
            DRAIN: begin
                // The presented entry stays in the FIFO until its write is granted.
                if (fb_we) begin
                    if (fb_grant) begin
                        fifo_pop = 1'b1;
                        if (!fifo_single) begin
                            addr_next = head_next.addr;
                            data_next = head_next.color;
                        end else begin
                            we_next = 1'b0;
                            if (!push) begin
                                if (clear_pending) begin
                                    state_next = CLEAR;
                                    we_next    = 1'b1;
                                    addr_next  = '0;
                                    data_next  = clear_col_q;
                                end else begin
                                    state_next = IDLE;
                                end
                            end
                        end
                    end
                end else if (!fifo_empty) begin
                    we_next   = 1'b1;
                    addr_next = head.addr;
                    data_next = head.color;
                end else begin
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                if (fb_grant) begin
                    if (fb_addr == LAST_ADDR) begin
                        we_next      = 1'b0;
                        done_next    = 1'b1;
                        pending_next = 1'b0;
                        state_next   = IDLE;
                    end else begin
                        addr_next = fb_addr + FB_ADDR_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            fb_we         <= 1'b0;
            fb_addr       <= '0;
            fb_data       <= '0;
            clear_done    <= 1'b0;
            clear_pending <= 1'b0;
            clear_col_q   <= '0;
            overflow      <= 1'b0;
            oor_count     <= '0;
        end else begin
            state         <= state_next;
            fb_we         <= we_next;
            fb_addr       <= addr_next;
            fb_data       <= data_next;
            clear_done    <= done_next;
            clear_pending <= pending_next;
            clear_col_q   <= clear_col_next;
            if (plot && !in_ready) begin
                overflow <= 1'b1;
            end
            if (accept && !in_range && (oor_count != 8'hFF)) begin
                oor_count <= oor_count + 8'd1;
            end
        end
    end

endmodule
